// File: rtl/regfile_ctrl_pkg.sv
// Shared types and defaults for the register-file operation sequencer.
package regfile_ctrl_pkg;

    localparam int RF_DATA_W = 4;
    localparam int RF_ADDR_W = 3;
    localparam int RF_CNT_W  = 8;

    // 3'b110 and 3'b111 are reserved and intentionally absent from the enum.
    typedef enum logic [2:0] {
        OP_PASS2 = 3'd0,
        OP_ADD   = 3'd1,
        OP_SUB   = 3'd2,
        OP_AND   = 3'd3,
        OP_LOADI = 3'd4,
        OP_CMP   = 3'd5
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_EXEC  = 2'd2,
        S_WRITE = 2'd3
    } state_e;

    function automatic logic op_writes(input op_e op);
        logic w;
        case (op)
            OP_PASS2, OP_ADD, OP_SUB, OP_AND, OP_LOADI: w = 1'b1;
            default:                                   w = 1'b0;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/regfile_op_sequencer_if.sv
// Command, register-file port and status bundle between front end, sequencer and register file.
interface regfile_op_sequencer_if #(
    parameter int DATA_W = 4,
    parameter int ADDR_W = 3,
    parameter int CNT_W  = 8
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [2:0]        cmd_op;
    logic [ADDR_W-1:0] cmd_src1;
    logic [ADDR_W-1:0] cmd_src2;
    logic [ADDR_W-1:0] cmd_dst;
    logic [DATA_W-1:0] cmd_imm;
    logic [ADDR_W-1:0] rf_raddr1;
    logic [ADDR_W-1:0] rf_raddr2;
    logic [DATA_W-1:0] rf_rdata1;
    logic [DATA_W-1:0] rf_rdata2;
    logic              rf_we;
    logic [ADDR_W-1:0] rf_waddr;
    logic [DATA_W-1:0] rf_wdata;
    logic [DATA_W-1:0] result;
    logic              result_valid;
    logic              flag_zero;
    logic              flag_carry;
    logic              flag_err;
    logic [CNT_W-1:0]  op_count;

    // master: requester plus register file; slave: the sequencer
    modport master (
        output cmd_valid, cmd_op, cmd_src1, cmd_src2, cmd_dst, cmd_imm,
        output rf_rdata1, rf_rdata2,
        input  cmd_ready, rf_raddr1, rf_raddr2, rf_we, rf_waddr, rf_wdata,
        input  result, result_valid, flag_zero, flag_carry, flag_err, op_count
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_src1, cmd_src2, cmd_dst, cmd_imm,
        input  rf_rdata1, rf_rdata2,
        output cmd_ready, rf_raddr1, rf_raddr2, rf_we, rf_waddr, rf_wdata,
        output result, result_valid, flag_zero, flag_carry, flag_err, op_count
    );
endinterface

// File: rtl/regfile_alu.sv
// Combinational ALU: evaluates one opcode on two register operands or the immediate.
module regfile_alu
    import regfile_ctrl_pkg::*;
#(
    parameter int DATA_W = RF_DATA_W
) (
    input  logic [2:0]        i_op,
    input  logic [DATA_W-1:0] i_a,
    input  logic [DATA_W-1:0] i_b,
    input  logic [DATA_W-1:0] i_imm,
    output logic [DATA_W-1:0] o_y,
    output logic              o_carry,
    output logic              o_err
);

    logic [DATA_W:0] w_sum;
    logic [DATA_W:0] w_diff;

    // The extra top bit carries out on ADD and is the borrow (a < b) on SUB/CMP.
    assign w_sum  = {1'b0, i_a} + {1'b0, i_b};
    assign w_diff = {1'b0, i_a} - {1'b0, i_b};

    always_comb begin
        o_y     = '0;
        o_carry = 1'b0;
        o_err   = 1'b0;
        case (i_op)
            OP_PASS2: o_y = i_b;
            OP_ADD: begin
                o_y     = w_sum[DATA_W-1:0];
                o_carry = w_sum[DATA_W];
            end
            OP_SUB, OP_CMP: begin
                o_y     = w_diff[DATA_W-1:0];
                o_carry = w_diff[DATA_W];
            end
            OP_AND:   o_y = i_a & i_b;
            OP_LOADI: o_y = i_imm;
            default:  o_err = 1'b1;
        endcase
    end

endmodule

// File: rtl/regfile_op_sequencer.sv
// Sequences one read-modify-write per command: IDLE -> READ -> EXEC -> WRITE.
module regfile_op_sequencer
    import regfile_ctrl_pkg::*;
#(
    parameter int DATA_W = RF_DATA_W,
    parameter int ADDR_W = RF_ADDR_W,
    parameter int CNT_W  = RF_CNT_W
) (
    input  logic                  clk,
    input  logic                  rst,
    regfile_op_sequencer_if.slave bus
);

    state_e            r_state;
    state_e            w_next;
    logic [2:0]        r_op;
    logic [ADDR_W-1:0] r_src1;
    logic [ADDR_W-1:0] r_src2;
    logic [ADDR_W-1:0] r_dst;
    logic [DATA_W-1:0] r_imm;
    logic [DATA_W-1:0] r_result;
    logic              r_zero;
    logic              r_carry;
    logic              r_err;
    logic [CNT_W-1:0]  r_count;

    logic              w_accept;
    logic [DATA_W-1:0] w_alu_y;
    logic              w_alu_carry;
    logic              w_alu_err;

    assign w_accept = (r_state == S_IDLE) && bus.cmd_valid;

    regfile_alu #(.DATA_W(DATA_W)) u_alu (
        .i_op    (r_op),
        .i_a     (bus.rf_rdata1),
        .i_b     (bus.rf_rdata2),
        .i_imm   (r_imm),
        .o_y     (w_alu_y),
        .o_carry (w_alu_carry),
        .o_err   (w_alu_err)
    );

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (bus.cmd_valid) w_next = S_READ;
            S_READ:  w_next = S_EXEC;
            S_EXEC:  w_next = S_WRITE;
            S_WRITE: w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Command fields stay latched through the op so the read addresses are stable in every state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_op     <= '0;
            r_src1   <= '0;
            r_src2   <= '0;
            r_dst    <= '0;
            r_imm    <= '0;
            r_result <= '0;
            r_zero   <= 1'b0;
            r_carry  <= 1'b0;
            r_err    <= 1'b0;
            r_count  <= '0;
        end else begin
            if (w_accept) begin
                r_op   <= bus.cmd_op;
                r_src1 <= bus.cmd_src1;
                r_src2 <= bus.cmd_src2;
                r_dst  <= bus.cmd_dst;
                r_imm  <= bus.cmd_imm;
            end
            if (r_state == S_EXEC) begin
                r_result <= w_alu_y;
                r_zero   <= (w_alu_y == '0);
                r_carry  <= w_alu_carry;
                r_err    <= w_alu_err;
            end
            if (r_state == S_WRITE) r_count <= r_count + 1'b1;
        end
    end

    always_comb begin
        bus.cmd_ready    = (r_state == S_IDLE);
        bus.rf_we        = (r_state == S_WRITE) && op_writes(op_e'(r_op));
        bus.result_valid = (r_state == S_WRITE);
        bus.rf_raddr1    = r_src1;
        bus.rf_raddr2    = r_src2;
        bus.rf_waddr     = r_dst;
        bus.rf_wdata     = r_result;
        bus.result       = r_result;
        bus.flag_zero    = r_zero;
        bus.flag_carry   = r_carry;
        bus.flag_err     = r_err;
        bus.op_count     = r_count;
    end

endmodule

// File: tb/tb_regfile_op_sequencer.sv
// Directed plus randomized bench with a mock 8x4 register file and an arithmetic reference model.
module tb_regfile_op_sequencer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;

    regfile_op_sequencer_if #(.DATA_W(4), .ADDR_W(3), .CNT_W(8)) bus();

    regfile_op_sequencer #(.DATA_W(4), .ADDR_W(3), .CNT_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    logic [3:0] rf [8] = '{default: 4'h0};
    assign bus.rf_rdata1 = rf[bus.rf_raddr1];
    assign bus.rf_rdata2 = rf[bus.rf_raddr2];
    always @(posedge clk) if (bus.rf_we) rf[bus.rf_waddr] <= bus.rf_wdata;

    int ref_rf [8] = '{default: 0};
    int ref_count = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void model(input int op, input int a, input int b, input int imm,
                                  output int y, output int c, output int e, output int w);
        y = 0; c = 0; e = 0; w = (op <= 4) ? 1 : 0;
        case (op)
            0: y = b;
            1: begin y = (a + b) % 16; c = (a + b > 15) ? 1 : 0; end
            2, 5: begin y = (a - b + 16) % 16; c = (a < b) ? 1 : 0; end
            3: y = a & b;
            4: y = imm;
            default: e = 1;
        endcase
    endfunction

    // busy: present a different command while the current one is in flight
    task automatic send(input int op, input int s1, input int s2, input int d, input int imm,
                        input bit busy);
        int waited, y, c, e, w;
        @(negedge clk);
        bus.cmd_op = 3'(op); bus.cmd_src1 = 3'(s1); bus.cmd_src2 = 3'(s2);
        bus.cmd_dst = 3'(d); bus.cmd_imm = 4'(imm); bus.cmd_valid = 1'b1;
        waited = 0;
        while (bus.cmd_ready !== 1'b1 && waited < 8) begin
            @(negedge clk);
            waited++;
        end
        chk("accept_wait", 32'(waited < 8), 32'd1);
        if (waited >= 8) begin
            bus.cmd_valid = 1'b0;
            return;
        end
        model(op, ref_rf[s1], ref_rf[s2], imm, y, c, e, w);
        @(posedge clk); #1;
        if (busy) begin
            bus.cmd_op = 3'(4); bus.cmd_src1 = 3'(s1 ^ 1); bus.cmd_dst = 3'(d ^ 1);
        end else begin
            bus.cmd_valid = 1'b0;
        end
        chk("read_ready", 32'(bus.cmd_ready), 32'd0);
        chk("read_we", 32'(bus.rf_we), 32'd0);
        chk("read_raddr1", 32'(bus.rf_raddr1), 32'(s1));
        chk("read_raddr2", 32'(bus.rf_raddr2), 32'(s2));
        @(posedge clk); #1;
        chk("exec_we", 32'(bus.rf_we), 32'd0);
        chk("exec_rvalid", 32'(bus.result_valid), 32'd0);
        chk("exec_ready", 32'(bus.cmd_ready), 32'd0);
        @(posedge clk); #1;
        chk("write_we", 32'(bus.rf_we), 32'(w));
        chk("write_rvalid", 32'(bus.result_valid), 32'd1);
        chk("write_result", 32'(bus.result), 32'(y));
        chk("write_zero", 32'(bus.flag_zero), 32'(y == 0));
        chk("write_carry", 32'(bus.flag_carry), 32'(c));
        chk("write_err", 32'(bus.flag_err), 32'(e));
        if (busy) chk("busy_raddr1_held", 32'(bus.rf_raddr1), 32'(s1));
        if (w != 0) begin
            chk("write_waddr", 32'(bus.rf_waddr), 32'(d));
            chk("write_wdata", 32'(bus.rf_wdata), 32'(y));
        end
        @(posedge clk); #1;
        if (w != 0) ref_rf[d] = y;
        ref_count = (ref_count + 1) % 256;
        chk("idle_count", 32'(bus.op_count), 32'(ref_count));
        chk("idle_ready", 32'(bus.cmd_ready), 32'd1);
        chk("idle_rvalid", 32'(bus.result_valid), 32'd0);
        chk("idle_result_held", 32'(bus.result), 32'(y));
        chk("idle_rf_dst", 32'(rf[d]), 32'(ref_rf[d]));
    endtask

    initial begin
        bus.cmd_valid = 1'b0; bus.cmd_op = '0; bus.cmd_src1 = '0; bus.cmd_src2 = '0;
        bus.cmd_dst = '0; bus.cmd_imm = '0;
        repeat (3) @(posedge clk);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        chk("rst_ready", 32'(bus.cmd_ready), 32'd1);
        chk("rst_we", 32'(bus.rf_we), 32'd0);
        chk("rst_rvalid", 32'(bus.result_valid), 32'd0);
        chk("rst_result", 32'(bus.result), 32'd0);
        chk("rst_flags", {29'd0, bus.flag_zero, bus.flag_carry, bus.flag_err}, 32'd0);
        chk("rst_count", 32'(bus.op_count), 32'd0);
        chk("rst_addrs", {20'd0, bus.rf_raddr1, bus.rf_raddr2, bus.rf_waddr, bus.rf_wdata}, 32'd0);

        send(4, 0, 0, 2, 9, 1'b0);
        send(4, 0, 0, 5, 6, 1'b0);
        chk("two_loadi_count", 32'(bus.op_count), 32'd2);
        send(1, 2, 5, 1, 0, 1'b0);
        chk("add_f", 32'(rf[1]), 32'hF);
        send(1, 1, 1, 1, 0, 1'b0);
        chk("add_e_carry", {27'd0, bus.flag_carry, rf[1]}, 32'h1E);
        send(2, 5, 2, 3, 0, 1'b0);
        chk("sub_d", 32'(rf[3]), 32'hD);
        send(5, 2, 2, 6, 0, 1'b0);
        chk("cmp_zero", 32'(bus.flag_zero), 32'd1);
        send(7, 3, 4, 0, 0, 1'b1);
        send(4, 0, 0, 7, 3, 1'b0);

        // Reset while the ADD into reg4 is in EXEC: write aborted, counter cleared.
        @(negedge clk);
        bus.cmd_op = 3'd1; bus.cmd_src1 = 3'd2; bus.cmd_src2 = 3'd5; bus.cmd_dst = 3'd4;
        bus.cmd_valid = 1'b1;
        chk("rst_test_ready", 32'(bus.cmd_ready), 32'd1);
        @(posedge clk); #1; bus.cmd_valid = 1'b0;
        @(posedge clk); #1; rst = 1'b1;
        @(posedge clk); #1;
        chk("midrst_we", 32'(bus.rf_we), 32'd0);
        chk("midrst_rvalid", 32'(bus.result_valid), 32'd0);
        chk("midrst_ready", 32'(bus.cmd_ready), 32'd1);
        chk("midrst_count", 32'(bus.op_count), 32'd0);
        @(negedge clk); rst = 1'b0; ref_count = 0;
        @(posedge clk); #1;
        chk("midrst_we_after", 32'(bus.rf_we), 32'd0);
        chk("midrst_reg4", 32'(rf[4]), 32'(ref_rf[4]));

        for (int i = 0; i < 256; i++)
            send(4, 0, 0, int'($urandom_range(0, 7)), int'($urandom_range(0, 15)), 1'b0);
        chk("count_wrap", 32'(bus.op_count), 32'd0);

        for (int i = 0; i < 60; i++)
            send(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                 int'($urandom_range(0, 7)), int'($urandom_range(0, 15)), $urandom_range(0, 3) == 0);
        bus.cmd_valid = 1'b0;
        @(posedge clk); #1;
        for (int r = 0; r < 8; r++) chk($sformatf("final_reg%0d", r), 32'(rf[r]), 32'(ref_rf[r]));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/regfile_op_sequencer.md
Name: regfile_op_sequencer

Overview:
- Command-driven controller that sequences one read-modify-write operation on the 8x4 register file and its ALU datapath.
- Accepts one command per valid/ready handshake: opcode, two source registers, one destination register, one immediate.
- Drives the register file read and write ports, computes the result, writes it back, and reports result and flags.
- Sits between the board front end (switch and button decode) and register_file_8x4. It replaces the free-running combinational operation select with a proper sequenced datapath.

Parameters:
- DATA_W, 4, register and data width in bits.
- ADDR_W, 3, register address width; the register file has 2**ADDR_W entries.
- CNT_W, 8, width of the completed-operation counter.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  controller can accept a command.
- cmd_op  input  3  opcode; see Behaviour.
- cmd_src1  input  ADDR_W  first source register.
- cmd_src2  input  ADDR_W  second source register.
- cmd_dst  input  ADDR_W  destination register.
- cmd_imm  input  DATA_W  immediate operand for LOADI.
- rf_raddr1  output  ADDR_W  register file read address 1.
- rf_raddr2  output  ADDR_W  register file read address 2.
- rf_rdata1  input  DATA_W  register file read data 1 (combinational read).
- rf_rdata2  input  DATA_W  register file read data 2 (combinational read).
- rf_we  output  1  register file write enable.
- rf_waddr  output  ADDR_W  register file write address.
- rf_wdata  output  DATA_W  register file write data.
- result  output  DATA_W  last computed result, held until the next EXEC.
- result_valid  output  1  one-cycle pulse when an operation completes.
- flag_zero  output  1  result == 0.
- flag_carry  output  1  ADD carry-out, or SUB/CMP borrow (src1 < src2).
- flag_err  output  1  last opcode was reserved.
- op_count  output  CNT_W  number of completed operations; wraps to 0 after the maximum value.

Behaviour:
- Reset is synchronous and active-high.
  - Reset values: state = IDLE; cmd_ready=1; rf_we=0; result_valid=0; result=0; all flags=0; op_count=0; latched fields=0.
  - rf_raddr1, rf_raddr2, rf_waddr and rf_wdata come from latched registers, so they also read 0 after reset.
- Opcode map:
  - 000 PASS2: result = src2.
  - 001 ADD: result = src1 + src2.
  - 010 SUB: result = src1 - src2.
  - 011 AND: result = src1 & src2.
  - 100 LOADI: result = imm.
  - 101 CMP: result = src1 - src2, no write-back.
  - 110, 111 reserved: result = 0, no write-back, flag_err = 1.
- Arithmetic width rules:
  - ADD and SUB results are modulo 2**DATA_W.
  - Carry and borrow are computed on a DATA_W+1 bit sum.
  - flag_carry = 0 for PASS2, AND and LOADI.
- State machine: IDLE -> READ -> EXEC -> WRITE -> IDLE.
  - IDLE: cmd_ready=1. When cmd_valid && cmd_ready, latch op, src1, src2, dst and imm, then go to READ. Without cmd_valid, stay in IDLE.
  - READ: cmd_ready=0. rf_raddr1/rf_raddr2 are driven from the latched sources; these addresses are held stable in every state. Go to EXEC.
  - EXEC: sample rf_rdata1/rf_rdata2, compute, and register result and all flags. Go to WRITE.
  - WRITE: rf_we=1 with rf_waddr=dst and rf_wdata=result, except for CMP and reserved opcodes, where rf_we=0. result_valid=1 and op_count increments. Go to IDLE.
- Latency and throughput:
  - A command accepted at edge N gives rf_we and result_valid high during cycle N+3.
  - Peak throughput is one command per 4 cycles; cmd_ready is high only in IDLE.
- Back-to-back dependency: the next command reads in READ, after the previous write has committed. A read-after-write to the same register therefore returns the new value, with no forwarding needed.
- src1 == src2 == dst is legal; the operation reads the old value and writes the new one.
- cmd_valid while busy is ignored; the command is not latched and the requester must hold it.
- Reset mid-operation: the controller returns to IDLE on the reset edge and the write is aborted (rf_we=0). Register file contents are not cleared by this block.

Decomposition:
- Package regfile_ctrl_pkg holds:
  - op_e enum: OP_PASS2, OP_ADD, OP_SUB, OP_AND, OP_LOADI, OP_CMP.
  - state_e enum: S_IDLE, S_READ, S_EXEC, S_WRITE.
  - DATA_W and ADDR_W defaults.
  - function op_writes(op_e): returns whether the opcode writes back.
- One combinational sub-module, regfile_alu: inputs op, a, b, imm; outputs y, carry, err. The sequencer instantiates it in EXEC.

Test Plan:
- Reset, then check idle state: cmd_ready=1, rf_we=0, result=0, op_count=0 -> all outputs at their reset values.
- LOADI dst=2 imm=9, then LOADI dst=5 imm=6 -> rf_we pulses 3 cycles after each accept; reg2=9, reg5=6; op_count=2.
- ADD src1=2 src2=5 dst=1 -> result=4'hF, carry=0, reg1=F. Then ADD src1=1 src2=1 dst=1 -> result=E, carry=1, reg1=E.
- SUB src1=5 src2=2 dst=3 -> 6-9 gives result=D, carry=1, zero=0. CMP src1=2 src2=2 -> result=0, zero=1, rf_we stays 0.
- Reserved op=111 -> result_valid pulses, flag_err=1, no write; cmd_valid held during a busy op -> accepted only once cmd_ready returns to 1.
- Assert rst in EXEC of ADD dst=4 -> no write to reg4, IDLE on the next cycle, op_count=0. Then 256 LOADI ops -> op_count wraps to 0.
